// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard, forwarding and stall controller for the 5-stage RV32I pipeline with
// variable-latency instruction and data memories. It sits beside the datapath
// and looks at register addresses and control bits from the D, E, M and W
// stages. From these it drives:
//   - the EX-stage forwarding mux selects;
//   - the per-stage stall enables of the dp_reg pipeline registers;
//   - the per-stage flush enables of the dp_reg pipeline registers.
//
// It also contains:
//   - a memory-wait FSM with a timeout error;
//   - saturating stall and flush performance counters.
//
// Parameters
//   AW        register-address width
//   FWD_EN    1 = forward from EX/MEM and MEM/WB
//             0 = no forwarding; stall D on any RAW against E, M or W
//   MAX_WAIT  consecutive data-memory wait cycles before mem_err is raised
//   CNT_W     width of the performance counters
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   rs1_d, rs2_d              ID source registers
//   use_rs1_d, use_rs2_d      ID instruction actually reads rs1 / rs2
//   rs1_e, rs2_e              EX source registers (forwarding consumers)
//   rd_e, reg_write_e         EX destination and its write enable
//   is_load_e                 EX instruction is a load
//   rd_m, reg_write_m         MEM destination and its write enable
//   rd_w, reg_write_w         WB destination and its write enable
//   pc_src_e                  taken branch / jump resolved in EX
//   mreq_m, mem_ready         data-memory request and completion
//   imem_ready                instruction word valid this cycle
//   forward_rs1/forward_rs2   00 register file, 01 EX/MEM, 10 MEM/WB
//   stall_f/d/e/m             hold PC, IF/ID, ID/EX, EX/MEM
//   flush_d/e/w               bubble into IF/ID, ID/EX, MEM/WB
//   mem_err                   sticky data-memory timeout flag
//   stall_cnt                 saturating count of cycles with stall_f high
//   flush_cnt                 saturating count of applied redirects
//   dbg_state                 FSM state: 0 IDLE, 1 WAIT, 2 ERR
//
// Handshake: the data memory owns completion. A request (mreq_m) is complete
// in the cycle where mem_ready is high; every cycle with mreq_m high and
// mem_ready low is a wait cycle, during which the whole pipeline is frozen
// from PC up to EX/MEM, and a bubble is pushed into MEM/WB. The instruction
// memory is treated the same way via imem_ready, but it only holds the front
// end.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int AW       = 5,
  parameter int FWD_EN   = 1,
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1_d,
  input  logic [AW-1:0]    rs2_d,
  input  logic             use_rs1_d,
  input  logic             use_rs2_d,
  input  logic [AW-1:0]    rs1_e,
  input  logic [AW-1:0]    rs2_e,
  input  logic [AW-1:0]    rd_e,
  input  logic             reg_write_e,
  input  logic             is_load_e,
  input  logic [AW-1:0]    rd_m,
  input  logic             reg_write_m,
  input  logic [AW-1:0]    rd_w,
  input  logic             reg_write_w,
  input  logic             pc_src_e,
  input  logic             mreq_m,
  input  logic             mem_ready,
  input  logic             imem_ready,
  output logic [1:0]       forward_rs1,
  output logic [1:0]       forward_rs2,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  // Wait counter is wide enough to hold MAX_WAIT itself.
  localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WCW-1:0]   r_wait_cnt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [WCW-1:0]   w_wait_inc;
  logic             w_mem_wait;
  logic             w_mem_stall;
  logic             w_raw_d;

  // Per-source match flags; x0 never matches.
  logic w_hit1_e, w_hit1_m, w_hit1_w;
  logic w_hit2_e, w_hit2_m, w_hit2_w;

  // ---------------------------------------------------------------------------
  // Forwarding selects. MEM/WB is only used when EX/MEM does not supply a
  // younger value for the same register.
  // ---------------------------------------------------------------------------
  always_comb begin
    forward_rs1 = 2'b00;
    forward_rs2 = 2'b00;
    if (FWD_EN != 0) begin
      if (reg_write_m && (rd_m != '0) && (rs1_e == rd_m)) begin
        forward_rs1 = 2'b01;
      end else if (reg_write_w && (rd_w != '0) && (rs1_e == rd_w)) begin
        forward_rs1 = 2'b10;
      end
      if (reg_write_m && (rd_m != '0) && (rs2_e == rd_m)) begin
        forward_rs2 = 2'b01;
      end else if (reg_write_w && (rd_w != '0) && (rs2_e == rd_w)) begin
        forward_rs2 = 2'b10;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAW detection for the instruction in ID.
  // ---------------------------------------------------------------------------
  assign w_hit1_e = use_rs1_d && (rs1_d != '0) && reg_write_e && (rs1_d == rd_e);
  assign w_hit1_m = use_rs1_d && (rs1_d != '0) && reg_write_m && (rs1_d == rd_m);
  assign w_hit1_w = use_rs1_d && (rs1_d != '0) && reg_write_w && (rs1_d == rd_w);
  assign w_hit2_e = use_rs2_d && (rs2_d != '0) && reg_write_e && (rs2_d == rd_e);
  assign w_hit2_m = use_rs2_d && (rs2_d != '0) && reg_write_m && (rs2_d == rd_m);
  assign w_hit2_w = use_rs2_d && (rs2_d != '0) && reg_write_w && (rs2_d == rd_w);

  always_comb begin
    w_raw_d = 1'b0;
    if (FWD_EN != 0) begin
      // With forwarding only a load in EX cannot be bypassed in time.
      w_raw_d = (w_hit1_e || w_hit2_e) && is_load_e;
    end else begin
      w_raw_d = w_hit1_e || w_hit2_e || w_hit1_m || w_hit2_m || w_hit1_w || w_hit2_w;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall / flush priority. A memory stall freezes EX, so pc_src_e is held
  // stable and the redirect is simply applied in the release cycle.
  // ---------------------------------------------------------------------------
  assign w_mem_wait  = mreq_m && !mem_ready;
  assign w_mem_stall = w_mem_wait || (r_state == ST_ERR);

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst) begin
      if (w_mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (pc_src_e) begin
        // A load-use consumer in ID is killed by this flush, so no stall.
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (w_raw_d) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else if (!imem_ready) begin
        stall_f = 1'b1;
        flush_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-wait FSM. The counter holds the number of consecutive wait cycles
  // seen so far, including the current one once registered.
  // ---------------------------------------------------------------------------
  assign w_wait_inc = r_wait_cnt + WCW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mem_wait) begin
            r_wait_cnt <= WCW'(1);
            if (MAX_WAIT <= 1) begin
              r_state   <= ST_ERR;
              r_mem_err <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Completion releases in the same cycle; a withdrawn request is
          // treated as complete so the counter cannot run on stale state.
          if (mem_ready || !mreq_m) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc >= WCW'(MAX_WAIT)) begin
              r_state   <= ST_ERR;
              r_mem_err <= 1'b1;
            end
          end
        end
        ST_ERR: begin
          r_mem_err <= 1'b1;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters. flush_cnt counts redirects actually
  // applied, i.e. not deferred by a memory stall.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_f && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (pc_src_e && !w_mem_stall && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for pipe_hazard_ctrl. Two instances share the same stimulus:
//   a: FWD_EN=1, MAX_WAIT=4,   CNT_W=8  (forwarding, timeout, saturation)
//   b: FWD_EN=0, MAX_WAIT=255, CNT_W=32 (stall-on-any-RAW policy)
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Control vectors are {stall_f,stall_d,stall_e,stall_m,
// flush_d,flush_e,flush_w}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus ----------------
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic use_rs1_d, use_rs2_d, reg_write_e, is_load_e, reg_write_m, reg_write_w;
  logic pc_src_e, mreq_m, mem_ready, imem_ready;

  // ---------------- instance a ----------------
  logic [1:0] a_fwd1, a_fwd2, a_state;
  logic a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw, a_err;
  logic [7:0] a_scnt, a_fcnt;
  logic [6:0] a_ctl;
  assign a_ctl = {a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw};

  // ---------------- instance b ----------------
  logic [1:0] b_fwd1, b_fwd2, b_state;
  logic b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fw, b_err;
  logic [31:0] b_scnt, b_fcnt;
  logic [6:0] b_ctl;
  assign b_ctl = {b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fw};

  pipe_hazard_ctrl #(.AW(5), .FWD_EN(1), .MAX_WAIT(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
    .is_load_e(is_load_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
    .mreq_m(mreq_m), .mem_ready(mem_ready), .imem_ready(imem_ready),
    .forward_rs1(a_fwd1), .forward_rs2(a_fwd2),
    .stall_f(a_sf), .stall_d(a_sd), .stall_e(a_se), .stall_m(a_sm),
    .flush_d(a_fd), .flush_e(a_fe), .flush_w(a_fw), .mem_err(a_err),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt), .dbg_state(a_state)
  );

  pipe_hazard_ctrl #(.AW(5), .FWD_EN(0), .MAX_WAIT(255), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
    .is_load_e(is_load_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
    .mreq_m(mreq_m), .mem_ready(mem_ready), .imem_ready(imem_ready),
    .forward_rs1(b_fwd1), .forward_rs2(b_fwd2),
    .stall_f(b_sf), .stall_d(b_sd), .stall_e(b_se), .stall_m(b_sm),
    .flush_d(b_fd), .flush_e(b_fe), .flush_w(b_fw), .mem_err(b_err),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt), .dbg_state(b_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Does a used ID source depend on an in-flight write it cannot get in time?
  function automatic logic model_hazard(input logic [4:0] rs, input logic use_rs, input bit fwd);
    if (!use_rs || rs == 5'd0) return 1'b0;
    if (reg_write_e && rs == rd_e && (is_load_e || !fwd)) return 1'b1;
    if (!fwd && reg_write_m && rs == rd_m) return 1'b1;
    if (!fwd && reg_write_w && rs == rd_w) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [6:0] model_ctl(input bit fwd, input bit err);
    logic raw;
    raw = model_hazard(rs1_d, use_rs1_d, fwd) || model_hazard(rs2_d, use_rs2_d, fwd);
    if (rst) return 7'b0000_000;
    if ((mreq_m && !mem_ready) || err) return 7'b1111_001;
    if (pc_src_e) return 7'b0000_110;
    if (raw) return 7'b1100_010;
    if (!imem_ready) return 7'b1000_100;
    return 7'b0000_000;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (rs != 5'd0 && reg_write_m && rs == rd_m) return 2'b01;
    if (rs != 5'd0 && reg_write_w && rs == rd_w) return 2'b10;
    return 2'b00;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    use_rs1_d = 0; use_rs2_d = 0; reg_write_e = 0; is_load_e = 0;
    reg_write_m = 0; reg_write_w = 0; pc_src_e = 0; mreq_m = 0;
    mem_ready = 1; imem_ready = 1;
  endtask

  // Leaves time just after a rising edge, with rst low and counters at 0.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    mreq_m = 1; mem_ready = 0; pc_src_e = 1; imem_ready = 0;
    is_load_e = 1; reg_write_e = 1; rd_e = 7; rs1_d = 7; use_rs1_d = 1;
    next_cycle();
    @(negedge clk);
    checks++; if (a_ctl !== 7'b0) begin errors++; $display("FAIL reset_ctl_a: got %b expected %b", a_ctl, 7'b0); end
    checks++; if (b_ctl !== 7'b0) begin errors++; $display("FAIL reset_ctl_b: got %b expected %b", b_ctl, 7'b0); end
    checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", a_state); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", a_err); end
    checks++; if (a_scnt !== 8'd0 || a_fcnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", a_scnt, a_fcnt); end
    next_cycle();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_forwarding();
    do_reset();
    rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5; rs2_e = 5;
    @(negedge clk);
    checks++; if (a_fwd1 !== 2'b01) begin errors++; $display("FAIL fwd_mem: got %b expected 01", a_fwd1); end
    checks++; if (a_fwd2 !== 2'b01) begin errors++; $display("FAIL fwd_mem_rs2: got %b expected 01", a_fwd2); end
    checks++; if (b_fwd1 !== 2'b00) begin errors++; $display("FAIL fwd_disabled: got %b expected 00", b_fwd1); end
    #1 rd_m = 0;
    #1;
    checks++; if (a_fwd1 !== 2'b10) begin errors++; $display("FAIL fwd_wb: got %b expected 10", a_fwd1); end
    #1 rs1_e = 0;
    #1;
    checks++; if (a_fwd1 !== 2'b00) begin errors++; $display("FAIL fwd_x0: got %b expected 00", a_fwd1); end
    checks++; if (a_fwd2 !== 2'b10) begin errors++; $display("FAIL fwd_wb_rs2: got %b expected 10", a_fwd2); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    is_load_e = 1; reg_write_e = 1; rd_e = 7; rs2_d = 7; use_rs2_d = 0;
    @(negedge clk);
    checks++; if (a_ctl !== 7'b0) begin errors++; $display("FAIL lu_unused: got %b expected %b", a_ctl, 7'b0); end
    next_cycle();
    use_rs2_d = 1;
    @(negedge clk);
    checks++; if (a_ctl !== 7'b1100_010) begin errors++; $display("FAIL lu_stall: got %b expected %b", a_ctl, 7'b1100_010); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (a_ctl !== 7'b0) begin errors++; $display("FAIL lu_release: got %b expected %b", a_ctl, 7'b0); end
    checks++; if (a_scnt !== 8'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", a_scnt); end
    next_cycle();
  endtask

  task automatic test_no_forward();
    do_reset();
    reg_write_w = 1; rd_w = 3; rs1_d = 3; use_rs1_d = 1; rs1_e = 3;
    @(negedge clk);
    checks++; if (b_ctl !== 7'b1100_010) begin errors++; $display("FAIL nofwd_stall: got %b expected %b", b_ctl, 7'b1100_010); end
    checks++; if (b_fwd1 !== 2'b00) begin errors++; $display("FAIL nofwd_sel: got %b expected 00", b_fwd1); end
    checks++; if (a_ctl !== 7'b0) begin errors++; $display("FAIL fwd_no_stall: got %b expected %b", a_ctl, 7'b0); end
    checks++; if (a_fwd1 !== 2'b10) begin errors++; $display("FAIL fwd_sel_wb: got %b expected 10", a_fwd1); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_branch_over_load_use();
    do_reset();
    is_load_e = 1; reg_write_e = 1; rd_e = 7; rs1_d = 7; use_rs1_d = 1; pc_src_e = 1;
    @(negedge clk);
    checks++; if (a_ctl !== 7'b0000_110) begin errors++; $display("FAIL br_lu_ctl: got %b expected %b", a_ctl, 7'b0000_110); end
    checks++; if (b_ctl !== 7'b0000_110) begin errors++; $display("FAIL br_lu_ctl_b: got %b expected %b", b_ctl, 7'b0000_110); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (a_fcnt !== 8'd1) begin errors++; $display("FAIL br_flush_cnt: got %0d expected 1", a_fcnt); end
    checks++; if (a_scnt !== 8'd0) begin errors++; $display("FAIL br_stall_cnt: got %0d expected 0", a_scnt); end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    mreq_m = 1; mem_ready = 0; pc_src_e = 1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (a_ctl !== 7'b1111_001) begin errors++; $display("FAIL wait_ctl c%0d: got %b expected %b", k, a_ctl, 7'b1111_001); end
      checks++; if (a_state !== ((k == 1) ? 2'd0 : 2'd1)) begin errors++; $display("FAIL wait_state c%0d: got %0d expected %0d", k, a_state, (k == 1) ? 0 : 1); end
      next_cycle();
    end
    mem_ready = 1;
    @(negedge clk);
    checks++; if (a_ctl !== 7'b0000_110) begin errors++; $display("FAIL wait_release: got %b expected %b", a_ctl, 7'b0000_110); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL wait_idle: got %0d expected 0", a_state); end
    checks++; if (a_scnt !== 8'd3) begin errors++; $display("FAIL wait_stall_cnt: got %0d expected 3", a_scnt); end
    checks++; if (a_fcnt !== 8'd1) begin errors++; $display("FAIL wait_flush_cnt: got %0d expected 1", a_fcnt); end
    next_cycle();
  endtask

  task automatic test_timeout();
    do_reset();
    mreq_m = 1; mem_ready = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++; if (a_err !== (k >= 5)) begin errors++; $display("FAIL tmo_err c%0d: got %b expected %b", k, a_err, (k >= 5)); end
      checks++; if (a_ctl !== 7'b1111_001) begin errors++; $display("FAIL tmo_ctl c%0d: got %b expected %b", k, a_ctl, 7'b1111_001); end
      next_cycle();
    end
    mreq_m = 0; mem_ready = 1;
    @(negedge clk);
    checks++; if (a_ctl !== 7'b1111_001 || a_state !== 2'd2) begin errors++; $display("FAIL tmo_frozen: got %b/%0d expected %b/2", a_ctl, a_state, 7'b1111_001); end
    next_cycle();
    rst = 1'b1;
    mreq_m = 1; mem_ready = 0;
    @(negedge clk);
    checks++; if (a_ctl !== 7'b0) begin errors++; $display("FAIL tmo_rst_ctl: got %b expected %b", a_ctl, 7'b0); end
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++; if (a_err !== 1'b0 || a_state !== 2'd0) begin errors++; $display("FAIL tmo_rst_state: got err=%b st=%0d expected err=0 st=0", a_err, a_state); end
    checks++; if (a_scnt !== 8'd0) begin errors++; $display("FAIL tmo_rst_cnt: got %0d expected 0", a_scnt); end
    checks++; if (a_ctl !== 7'b0) begin errors++; $display("FAIL tmo_no_residual: got %b expected %b", a_ctl, 7'b0); end
    next_cycle();
  endtask

  task automatic test_saturation();
    do_reset();
    imem_ready = 0;
    for (int k = 0; k < 260; k++) next_cycle();
    imem_ready = 1;
    @(negedge clk);
    checks++; if (a_scnt !== 8'hFF) begin errors++; $display("FAIL sat_cnt_a: got %0d expected 255", a_scnt); end
    checks++; if (b_scnt !== 32'd260) begin errors++; $display("FAIL sat_cnt_b: got %0d expected 260", b_scnt); end
    next_cycle();
  endtask

  task automatic test_random();
    int run_a, run_b, scnt_a, fcnt_a, scnt_b, fcnt_b;
    bit err_a, err_b;
    logic [6:0] ea, eb;
    logic [1:0] est;
    run_a = 0; run_b = 0; scnt_a = 0; fcnt_a = 0; scnt_b = 0; fcnt_b = 0;
    err_a = 0; err_b = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3));
      rd_w = 5'($urandom_range(0, 3));
      use_rs1_d = 1'($urandom); use_rs2_d = 1'($urandom);
      reg_write_e = 1'($urandom); is_load_e = 1'($urandom);
      reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
      pc_src_e = ($urandom_range(0, 5) == 0);
      mreq_m = ($urandom_range(0, 2) == 0);
      mem_ready = (run_a >= 2) ? 1'b1 : 1'($urandom);
      imem_ready = ($urandom_range(0, 4) != 0);
      @(negedge clk);
      ea = model_ctl(1'b1, err_a);
      eb = model_ctl(1'b0, err_b);
      est = err_a ? 2'd2 : ((run_a > 0) ? 2'd1 : 2'd0);
      checks++; if (a_ctl !== ea) begin errors++; $display("FAIL rnd_ctl_a n%0d: got %b expected %b", n, a_ctl, ea); end
      checks++; if (b_ctl !== eb) begin errors++; $display("FAIL rnd_ctl_b n%0d: got %b expected %b", n, b_ctl, eb); end
      checks++; if (a_fwd1 !== model_fwd(rs1_e) || a_fwd2 !== model_fwd(rs2_e)) begin errors++; $display("FAIL rnd_fwd_a n%0d: got %b/%b expected %b/%b", n, a_fwd1, a_fwd2, model_fwd(rs1_e), model_fwd(rs2_e)); end
      checks++; if (b_fwd1 !== 2'b00 || b_fwd2 !== 2'b00) begin errors++; $display("FAIL rnd_fwd_b n%0d: got %b/%b expected 00/00", n, b_fwd1, b_fwd2); end
      checks++; if (a_state !== est || a_err !== err_a) begin errors++; $display("FAIL rnd_fsm_a n%0d: got st=%0d err=%b expected st=%0d err=%b", n, a_state, a_err, est, err_a); end
      checks++; if (a_scnt !== 8'(scnt_a) || a_fcnt !== 8'(fcnt_a)) begin errors++; $display("FAIL rnd_cnt_a n%0d: got %0d/%0d expected %0d/%0d", n, a_scnt, a_fcnt, scnt_a, fcnt_a); end
      checks++; if (b_scnt !== 32'(scnt_b) || b_fcnt !== 32'(fcnt_b)) begin errors++; $display("FAIL rnd_cnt_b n%0d: got %0d/%0d expected %0d/%0d", n, b_scnt, b_fcnt, scnt_b, fcnt_b); end
      // Advance the model across the coming edge.
      if (ea[6] && scnt_a < 255) scnt_a++;
      if (pc_src_e && ea[0] == 1'b0 && fcnt_a < 255) fcnt_a++;
      scnt_b += eb[6];
      if (pc_src_e && eb[0] == 1'b0) fcnt_b++;
      if (!err_a) begin
        if (mreq_m && !mem_ready) begin run_a++; if (run_a >= 4) err_a = 1; end
        else run_a = 0;
      end
      if (!err_b) begin
        if (mreq_m && !mem_ready) begin run_b++; if (run_b >= 255) err_b = 1; end
        else run_b = 0;
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_no_forward();
    test_branch_over_load_use();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
